// File: rtl/hvac_pkg.sv
// Shared constants and state encoding for the HVAC controller slice.
package hvac_pkg;

    localparam int unsigned TEMP_W      = 7;
    localparam int unsigned HYST_DEF    = 1;
    localparam int unsigned MIN_ON_DEF  = 16;
    localparam int unsigned LOCKOUT_DEF = 16;
    localparam int unsigned TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEAT    = 3'd1,
        ST_COOL    = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

endpackage

// File: rtl/hvac_if.sv
// Setpoint/sensor inputs and actuator/status outputs of the HVAC controller.
interface hvac_if;
    import hvac_pkg::*;

    logic [TEMP_W-1:0] temperature_registered;
    logic [TEMP_W-1:0] current_temp;
    logic              temp_valid;
    logic              heat_on;
    logic              cool_on;
    logic              fault;
    logic [2:0]        state_o;

    modport master (
        output temperature_registered, current_temp, temp_valid,
        input  heat_on, cool_on, fault, state_o
    );

    modport slave (
        input  temperature_registered, current_temp, temp_valid,
        output heat_on, cool_on, fault, state_o
    );

endinterface

// File: rtl/hvac_watchdog.sv
// Sensor-staleness watchdog: saturating counter cleared by each temperature strobe.
module hvac_watchdog #(
    parameter int unsigned TIMEOUT = hvac_pkg::TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expire
);

    localparam int unsigned   CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + CW'(1);
        end
    end

    // A strobe landing in the expiry cycle suppresses the fault.
    assign expire = (count == LAST) && !clear;

endmodule

// File: rtl/hvac_ctrl.sv
// Hysteresis thermostat FSM with minimum run time, post-run lockout and stale-sensor fault.
module hvac_ctrl
    import hvac_pkg::*;
#(
    parameter int unsigned HYST    = HYST_DEF,
    parameter int unsigned MIN_ON  = MIN_ON_DEF,
    parameter int unsigned LOCKOUT = LOCKOUT_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    hvac_if.slave bus
);

    localparam int unsigned   DMAX    = (MIN_ON > LOCKOUT) ? MIN_ON : LOCKOUT;
    localparam int unsigned   DW      = $clog2(DMAX + 1);
    localparam logic [DW-1:0] ON_LAST = DW'(MIN_ON - 1);
    localparam logic [DW-1:0] ON_SAT  = DW'(MIN_ON);
    localparam logic [DW-1:0] LK_LAST = DW'(LOCKOUT - 1);
    localparam logic [7:0]    HYST8   = 8'(HYST);

    state_t            state, state_nxt;
    logic [TEMP_W-1:0] meas_q;
    logic              seen;
    logic [DW-1:0]     dwell, dwell_nxt;
    logic              heat_q, cool_q, fault_q;
    logic              expire;
    logic [7:0]        meas8, sp8;
    logic              cold, hot;

    hvac_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (bus.temp_valid),
        .expire (expire)
    );

    // 8-bit compares so setpoint + HYST never wraps.
    assign meas8 = 8'(meas_q);
    assign sp8   = 8'(bus.temperature_registered);
    assign cold  = (meas8 + HYST8) < sp8;
    assign hot   = meas8 > (sp8 + HYST8);

    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell;
        if (expire && state != ST_FAULT) begin
            state_nxt = ST_FAULT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (seen && cold) begin
                        state_nxt = ST_HEAT;
                        dwell_nxt = '0;
                    end else if (seen && hot) begin
                        state_nxt = ST_COOL;
                        dwell_nxt = '0;
                    end
                end
                ST_HEAT: begin
                    if (dwell >= ON_LAST && meas8 >= sp8) begin
                        state_nxt = ST_LOCKOUT;
                        dwell_nxt = '0;
                    end else if (dwell != ON_SAT) begin
                        dwell_nxt = dwell + DW'(1);
                    end
                end
                ST_COOL: begin
                    if (dwell >= ON_LAST && meas8 <= sp8) begin
                        state_nxt = ST_LOCKOUT;
                        dwell_nxt = '0;
                    end else if (dwell != ON_SAT) begin
                        dwell_nxt = dwell + DW'(1);
                    end
                end
                ST_LOCKOUT: begin
                    if (dwell >= LK_LAST) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        dwell_nxt = dwell + DW'(1);
                    end
                end
                ST_FAULT: begin
                    if (bus.temp_valid) begin
                        state_nxt = ST_LOCKOUT;
                        dwell_nxt = '0;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            meas_q  <= '0;
            seen    <= 1'b0;
            dwell   <= '0;
            heat_q  <= 1'b0;
            cool_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            if (bus.temp_valid) begin
                meas_q <= bus.current_temp;
                seen   <= 1'b1;
            end
            state   <= state_nxt;
            dwell   <= dwell_nxt;
            heat_q  <= (state_nxt == ST_HEAT);
            cool_q  <= (state_nxt == ST_COOL);
            fault_q <= (state_nxt == ST_FAULT);
        end
    end

    assign bus.heat_on = heat_q;
    assign bus.cool_on = cool_q;
    assign bus.fault   = fault_q;
    assign bus.state_o = state;

endmodule

// File: tb/tb_hvac_ctrl.sv
// Directed self-checking bench for hvac_ctrl with hand-computed expectations.
module tb_hvac_ctrl;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    hvac_if bus ();

    hvac_ctrl #(
        .HYST    (1),
        .MIN_ON  (16),
        .LOCKOUT (16),
        .TIMEOUT (1024)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "time limit");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [6:0] v);
        bus.current_temp = v;
        bus.temp_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.temp_valid   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus.temperature_registered = 7'd22;
        bus.current_temp = 7'd0;
        bus.temp_valid   = 1'b0;
        step(3);
        chk("rst_state", 8'(bus.state_o), 8'd0);
        chk("rst_heat",  8'(bus.heat_on), 8'd0);
        chk("rst_cool",  8'(bus.cool_on), 8'd0);
        chk("rst_fault", 8'(bus.fault),   8'd0);
        reset = 1'b1;
        step(5);
        chk("idle_unseen", 8'(bus.state_o), 8'd0);

        // meas 21 is inside the band: no heat
        strobe(7'd21);
        step(2);
        chk("band_heat",  8'(bus.heat_on), 8'd0);
        chk("band_state", 8'(bus.state_o), 8'd0);

        // meas 20 is cold: heat two edges after strobe
        strobe(7'd20);
        chk("heat_lat1", 8'(bus.heat_on), 8'd0);
        step(1);
        chk("heat_on",    8'(bus.heat_on), 8'd1);
        chk("heat_state", 8'(bus.state_o), 8'd1);
        step(3);
        strobe(7'd23);
        step(11);
        chk("heat_minon",  8'(bus.heat_on), 8'd1);
        step(1);
        chk("heat_off",    8'(bus.heat_on), 8'd0);
        chk("heat_lockst", 8'(bus.state_o), 8'd3);
        step(15);
        chk("lock_hold", 8'(bus.state_o), 8'd3);
        step(1);
        chk("lock_idle", 8'(bus.state_o), 8'd0);
        step(2);
        chk("idle_23", 8'(bus.state_o), 8'd0);

        // meas 24 is hot: cool; meas 22 ends run after MIN_ON
        strobe(7'd24);
        step(1);
        chk("cool_on",    8'(bus.cool_on), 8'd1);
        chk("cool_state", 8'(bus.state_o), 8'd2);
        step(2);
        strobe(7'd22);
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("cool_hold", 8'(bus.cool_on), 8'd1);
            chk("cool_noheat", 8'(bus.heat_on), 8'd0);
        end
        step(1);
        chk("cool_off",    8'(bus.cool_on), 8'd0);
        chk("cool_lockst", 8'(bus.state_o), 8'd3);
        step(15);
        chk("clock_hold", 8'(bus.state_o), 8'd3);
        step(1);
        chk("clock_idle", 8'(bus.state_o), 8'd0);

        // watchdog expiry while heating
        strobe(7'd20);
        step(1);
        chk("wd_heat", 8'(bus.heat_on), 8'd1);
        step(1022);
        chk("wd_pre_state", 8'(bus.state_o), 8'd1);
        chk("wd_pre_fault", 8'(bus.fault),   8'd0);
        step(1);
        chk("wd_heat_off", 8'(bus.heat_on), 8'd0);
        chk("wd_fault",    8'(bus.fault),   8'd1);
        chk("wd_state",    8'(bus.state_o), 8'd4);
        step(5);
        strobe(7'd20);
        chk("flt_lock",   8'(bus.state_o), 8'd3);
        chk("flt_clear",  8'(bus.fault),   8'd0);
        chk("flt_noheat", 8'(bus.heat_on), 8'd0);
        step(15);
        chk("flt_lock_hold", 8'(bus.state_o), 8'd3);
        step(1);
        chk("flt_idle", 8'(bus.state_o), 8'd0);
        step(1);
        chk("flt_reheat", 8'(bus.heat_on), 8'd1);

        // strobe exactly in the expiry cycle
        step(1006);
        strobe(7'd20);
        chk("coin_fault", 8'(bus.fault),   8'd0);
        chk("coin_state", 8'(bus.state_o), 8'd1);
        step(1023);
        chk("coin_restart", 8'(bus.fault), 8'd0);
        step(1);
        chk("coin_expire",  8'(bus.fault), 8'd1);

        // get into COOL, then reset mid-run
        strobe(7'd24);
        chk("r_lock", 8'(bus.state_o), 8'd3);
        step(16);
        chk("r_idle", 8'(bus.state_o), 8'd0);
        step(1);
        chk("r_cool", 8'(bus.cool_on), 8'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("r_async_cool",  8'(bus.cool_on), 8'd0);
        chk("r_async_state", 8'(bus.state_o), 8'd0);
        bus.temperature_registered = 7'd18;
        step(3);
        reset = 1'b1;
        step(5);
        chk("r_unseen", 8'(bus.state_o), 8'd0);
        chk("r_noheat", 8'(bus.heat_on), 8'd0);
        strobe(7'd30);
        chk("r_lat", 8'(bus.state_o), 8'd0);
        step(1);
        chk("r_cool2",  8'(bus.cool_on), 8'd1);
        chk("r_state2", 8'(bus.state_o), 8'd2);
        chk("r_heat2",  8'(bus.heat_on), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
